// File: rtl/led_engine_pkg.sv
// Shared definitions for the LED pulse stretcher/blinker: channel mode
// encodings and a constant-function log2 used to size narrow counters.
package led_engine_pkg;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_STRETCH = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_BLINK   = 2'b11;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned     r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/led_array_engine_channel.sv
// One LED channel: edge detect, mode tracking, tick-driven countdown for
// stretch/oneshot and a phase counter for blink bursts.
module led_channel
  import led_engine_pkg::*;
#(
  parameter int unsigned CNTW    = 32,
  parameter int unsigned STRETCH = 12500000,
  parameter int unsigned PHASE   = 3125000,
  parameter int unsigned NBLINK  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       trig,
  input  logic [1:0] mode,
  input  logic       lamp_test,
  output logic       led,
  output logic       active
);

  localparam int unsigned PHW_RAW = clog2(longint'(2 * NBLINK + 1));
  localparam int unsigned PHW     = (PHW_RAW == 0) ? 1 : PHW_RAW;

  localparam logic [CNTW-1:0] CNT_ONE     = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_STRETCH = CNTW'(STRETCH);
  localparam logic [CNTW-1:0] CNT_PHASE   = CNTW'(PHASE);
  localparam logic [PHW-1:0]  PH_ONE      = PHW'(1);
  localparam logic [PHW-1:0]  PH_BURST    = PHW'(2 * NBLINK);

  logic            r_trig_d;
  logic [1:0]      r_mode_d;
  logic [CNTW-1:0] r_cnt;
  logic [PHW-1:0]  r_ph;
  logic            r_led;

  logic            w_rise;
  logic            w_mode_chg;
  logic [CNTW-1:0] w_cnt_n;
  logic [PHW-1:0]  w_ph_n;
  logic            w_on_n;
  logic            w_active_n;

  assign w_rise     = trig & ~r_trig_d;
  assign w_mode_chg = (mode != r_mode_d);

  // A load always beats a decrement landing on the same cycle.
  always_comb begin
    w_cnt_n = r_cnt;
    w_ph_n  = r_ph;
    if (w_mode_chg) begin
      w_cnt_n = '0;
      w_ph_n  = '0;
    end else begin
      case (mode)
        MODE_STRETCH: begin
          w_ph_n = '0;
          if (w_rise) begin
            w_cnt_n = CNT_STRETCH;
          end else if (tick && (r_cnt != '0)) begin
            w_cnt_n = r_cnt - CNT_ONE;
          end
        end
        MODE_ONESHOT: begin
          w_ph_n = '0;
          if (w_rise && (r_cnt == '0)) begin
            w_cnt_n = CNT_STRETCH;
          end else if (tick && (r_cnt != '0)) begin
            w_cnt_n = r_cnt - CNT_ONE;
          end
        end
        MODE_BLINK: begin
          if (w_rise) begin
            w_ph_n  = PH_BURST;
            w_cnt_n = CNT_PHASE;
          end else if (tick && (r_cnt != '0)) begin
            if (r_cnt == CNT_ONE) begin
              if (r_ph > PH_ONE) begin
                w_ph_n  = r_ph - PH_ONE;
                w_cnt_n = CNT_PHASE;
              end else begin
                w_ph_n  = '0;
                w_cnt_n = '0;
              end
            end else begin
              w_cnt_n = r_cnt - CNT_ONE;
            end
          end
        end
        default: begin
          w_cnt_n = '0;
          w_ph_n  = '0;
        end
      endcase
    end
  end

  // Blink phases count down from an even value, so even phases are lit.
  always_comb begin
    w_on_n     = 1'b0;
    w_active_n = 1'b0;
    if (mode == MODE_BLINK) begin
      w_active_n = (w_ph_n != '0);
      w_on_n     = (w_ph_n != '0) && !w_ph_n[0];
    end else begin
      w_active_n = (w_cnt_n != '0);
      w_on_n     = (w_cnt_n != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_d <= 1'b1;
      r_mode_d <= MODE_OFF;
      r_cnt    <= '0;
      r_ph     <= '0;
      r_led    <= 1'b0;
    end else begin
      r_trig_d <= trig;
      r_mode_d <= mode;
      r_cnt    <= w_cnt_n;
      r_ph     <= w_ph_n;
      r_led    <= lamp_test | w_on_n;
    end
  end

  assign led    = r_led;
  assign active = w_active_n;

endmodule

// File: rtl/led_array_engine.sv
// Multi-channel LED pulse stretcher/blinker: shared tick prescaler, one
// led_channel per LED and a registered busy summary.
module led_array_engine
  import led_engine_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned PRESC   = 1,
  parameter int unsigned STRETCH = 12500000,
  parameter int unsigned PHASE   = 3125000,
  parameter int unsigned NBLINK  = 3,
  parameter int unsigned CNTW    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   trig,
  input  logic [2*NCH-1:0] mode,
  input  logic             lamp_test,
  output logic [NCH-1:0]   led,
  output logic             busy
);

  localparam longint unsigned MAX_LD = (STRETCH > PHASE) ? longint'(STRETCH) : longint'(PHASE);
  localparam int unsigned     PW_RAW = clog2(longint'(PRESC));
  localparam int unsigned     PW     = (PW_RAW == 0) ? 1 : PW_RAW;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESC - 1);
  localparam logic [PW-1:0]   PRE_ONE  = PW'(1);

  if ((CNTW < 64) && ((MAX_LD >> CNTW) != 0)) begin : g_cntw_check
    $error("led_array_engine: CNTW too narrow for max(STRETCH, PHASE)");
  end
  if ((NCH < 1) || (NCH > 32) || (PRESC < 1) || (STRETCH < 1) || (PHASE < 1) || (NBLINK < 1)) begin : g_param_check
    $error("led_array_engine: parameter out of range");
  end

  logic [PW-1:0]  r_pre;
  logic           r_busy;
  logic           w_tick;
  logic [NCH-1:0] w_active;

  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_ONE;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    led_channel #(
      .CNTW    (CNTW),
      .STRETCH (STRETCH),
      .PHASE   (PHASE),
      .NBLINK  (NBLINK)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (w_tick),
      .trig      (trig[gi]),
      .mode      (mode[2*gi+1:2*gi]),
      .lamp_test (lamp_test),
      .led       (led[gi]),
      .active    (w_active[gi])
    );
  end

  // Lamp test drives the LEDs only; busy reflects real channel activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= |w_active;
    end
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_led_array_engine.sv
// Directed bench for led_array_engine: stretch, retrigger/oneshot, blink,
// prescaler timing, mode change, lamp test and asynchronous reset.
module tb_led_array_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] trig;
  logic [7:0] mode;
  logic       lamp_test;
  logic [3:0] led;
  logic       busy;

  logic       trig_p;
  logic [1:0] mode_p;
  logic       lamp_p;
  logic [0:0] led_p;
  logic       busy_p;

  int         cmp_cnt = 0;
  int         err_cnt = 0;
  logic [2:0] tb_pre;

  always #5 clk = ~clk;

  led_array_engine #(
    .NCH(4), .PRESC(1), .STRETCH(10), .PHASE(4), .NBLINK(3), .CNTW(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .mode(mode),
    .lamp_test(lamp_test), .led(led), .busy(busy)
  );

  led_array_engine #(
    .NCH(1), .PRESC(5), .STRETCH(3), .PHASE(2), .NBLINK(1), .CNTW(4)
  ) u_dut_p (
    .clk(clk), .rst_n(rst_n), .trig(trig_p), .mode(mode_p),
    .lamp_test(lamp_p), .led(led_p), .busy(busy_p)
  );

  // Reference prescaler phase: value held after each edge, 0..4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_pre <= 3'd0;
    else        tb_pre <= (tb_pre == 3'd4) ? 3'd0 : tb_pre + 3'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    trig      = 4'b0000;
    mode      = 8'b00_11_10_01;
    lamp_test = 1'b0;
    trig_p    = 1'b0;
    mode_p    = 2'b01;
    lamp_p    = 1'b0;
    #12;
    cmp_cnt++;
    if (led !== 4'b0000) begin err_cnt++; $display("FAIL reset_led got=%b exp=0000", led); end
    cmp_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%b exp=0", busy); end
    cmp_cnt++;
    if (led_p !== 1'b0) begin err_cnt++; $display("FAIL reset_led_p got=%b exp=0", led_p); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    cmp_cnt++;
    if (led !== 4'b0000 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL post_reset got led=%b busy=%b exp 0000/0", led, busy);
    end
  endtask

  task automatic test_stretch();
    logic [3:0] exp_led;
    for (int k = 0; k < 15; k++) begin
      trig = (k == 0) ? 4'b0001 : 4'b0000;
      step();
      exp_led = {3'b000, (k < 10)};
      cmp_cnt++;
      if (led !== exp_led) begin err_cnt++; $display("FAIL stretch_led k=%0d got=%b exp=%b", k, led, exp_led); end
      cmp_cnt++;
      if (busy !== (k < 10)) begin err_cnt++; $display("FAIL stretch_busy k=%0d got=%b exp=%b", k, busy, (k < 10)); end
    end
  endtask

  task automatic test_retrigger();
    logic [3:0] exp_led;
    for (int k = 0; k < 20; k++) begin
      trig = (k == 0 || k == 5) ? 4'b0011 : 4'b0000;
      step();
      exp_led = {2'b00, (k < 10), (k < 15)};
      cmp_cnt++;
      if (led !== exp_led) begin err_cnt++; $display("FAIL retrig_led k=%0d got=%b exp=%b", k, led, exp_led); end
      cmp_cnt++;
      if (busy !== (k < 15)) begin err_cnt++; $display("FAIL retrig_busy k=%0d got=%b exp=%b", k, busy, (k < 15)); end
    end
  endtask

  task automatic test_blink();
    logic [3:0] exp_led;
    logic       exp2;
    int         j;
    for (int k = 0; k < 30; k++) begin
      trig = (k == 0) ? 4'b0100 : 4'b0000;
      step();
      exp2    = (k < 24) && (((k / 4) % 2) == 0);
      exp_led = {1'b0, exp2, 2'b00};
      cmp_cnt++;
      if (led !== exp_led) begin err_cnt++; $display("FAIL blink_led k=%0d got=%b exp=%b", k, led, exp_led); end
      cmp_cnt++;
      if (busy !== (k < 24)) begin err_cnt++; $display("FAIL blink_busy k=%0d got=%b exp=%b", k, busy, (k < 24)); end
    end
    step();
    step();
    for (int k = 0; k < 38; k++) begin
      trig = (k == 0 || k == 9) ? 4'b0100 : 4'b0000;
      step();
      j       = (k < 9) ? k : k - 9;
      exp2    = (j < 24) && (((j / 4) % 2) == 0);
      exp_led = {1'b0, exp2, 2'b00};
      cmp_cnt++;
      if (led !== exp_led) begin err_cnt++; $display("FAIL blink_rt_led k=%0d got=%b exp=%b", k, led, exp_led); end
      cmp_cnt++;
      if (busy !== (j < 24)) begin err_cnt++; $display("FAIL blink_rt_busy k=%0d got=%b exp=%b", k, busy, (j < 24)); end
    end
  endtask

  task automatic presc_pulse(input string name);
    int d;
    int w;
    d = (tb_pre == 3'd4) ? 5 : (4 - int'(tb_pre));
    trig_p = 1'b1;
    step();
    trig_p = 1'b0;
    w = 0;
    while (led_p[0] && w < 40) begin
      w++;
      step();
    end
    cmp_cnt++;
    if (w !== d + 10) begin err_cnt++; $display("FAIL %s width got=%0d exp=%0d", name, w, d + 10); end
    cmp_cnt++;
    if (w < 11 || w > 15) begin err_cnt++; $display("FAIL %s range got=%0d exp=11..15", name, w); end
  endtask

  task automatic test_prescaler();
    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(0, 9)) step();
      presc_pulse("presc_rand");
    end
    for (int t = 0; t < 10 && tb_pre != 3'd4; t++) step();
    cmp_cnt++;
    if (tb_pre != 3'd4) begin
      err_cnt++; $display("FAIL presc_align got=%0d exp=4", tb_pre);
    end else begin
      presc_pulse("presc_tick_load");
    end
  endtask

  task automatic test_boundary();
    rst_n = 1'b0;
    trig  = 4'b0001;
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    cmp_cnt++;
    if (led !== 4'b0000 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL held_trig got led=%b busy=%b exp 0000/0", led, busy);
    end
    trig = 4'b0000;
    step();
    step();
    trig = 4'b0001;
    step();
    trig = 4'b0000;
    step();
    step();
    cmp_cnt++;
    if (led !== 4'b0001) begin err_cnt++; $display("FAIL mode_pre got=%b exp=0001", led); end
    mode[1:0] = 2'b00;
    step();
    cmp_cnt++;
    if (led !== 4'b0000 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL mode_clear got led=%b busy=%b exp 0000/0", led, busy);
    end
    mode[1:0] = 2'b01;
    trig      = 4'b0001;
    step();
    cmp_cnt++;
    if (led !== 4'b0000) begin err_cnt++; $display("FAIL mode_chg_rise got=%b exp=0000", led); end
    step();
    cmp_cnt++;
    if (led !== 4'b0000) begin err_cnt++; $display("FAIL mode_chg_hold got=%b exp=0000", led); end
    trig      = 4'b0000;
    lamp_test = 1'b1;
    step();
    cmp_cnt++;
    if (led !== 4'b1111) begin err_cnt++; $display("FAIL lamp_on got=%b exp=1111", led); end
    cmp_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL lamp_busy got=%b exp=0", busy); end
    lamp_test = 1'b0;
    step();
    cmp_cnt++;
    if (led !== 4'b0000) begin err_cnt++; $display("FAIL lamp_off got=%b exp=0000", led); end
  endtask

  task automatic test_async_reset();
    trig = 4'b0100;
    step();
    trig = 4'b0000;
    step();
    step();
    cmp_cnt++;
    if (led !== 4'b0100 || busy !== 1'b1) begin
      err_cnt++; $display("FAIL ares_pre got led=%b busy=%b exp 0100/1", led, busy);
    end
    #3;
    rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if (led !== 4'b0000 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL ares_now got led=%b busy=%b exp 0000/0", led, busy);
    end
    #1;
    rst_n = 1'b1;
    repeat (5) step();
    cmp_cnt++;
    if (led !== 4'b0000 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL ares_idle got led=%b busy=%b exp 0000/0", led, busy);
    end
    trig = 4'b0001;
    step();
    trig = 4'b0000;
    cmp_cnt++;
    if (led !== 4'b0001 || busy !== 1'b1) begin
      err_cnt++; $display("FAIL ares_new got led=%b busy=%b exp 0001/1", led, busy);
    end
    repeat (12) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stretch();
    test_retrigger();
    test_blink();
    test_prescaler();
    test_boundary();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
